// File: rtl/regfile_arb_pkg.sv
// Shared types and helpers for the register-file port arbiter.
package regfile_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int LOCK_CNT_W = 4;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module rr_pick
  import regfile_arb_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && valid[j]) begin
        any      = 1'b1;
        idx      = IW'(j);
        grant[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing one register-file read and write port, with bounded lock.
// Optional REGFILE_ARB_ZERO_PROTECT_EN makes address 0 read as zero and ignore writes.
//
// state  | meaning
// ARB    | round-robin among all valid requesters
// LOCKED | only owner may be granted, bounded by MAX_LOCK
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter  int NUM_REQ        = 2,
  parameter  int NUM_OF_SETS    = 32,
  parameter  int DATA_BUS_WIDTH = 32,
  parameter  int MAX_LOCK       = 4,
  localparam int AW             = idx_w(NUM_OF_SETS),
  localparam int DW             = DATA_BUS_WIDTH,
  localparam int IW             = idx_w(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ-1:0]    req_lock,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic                  rf_wr_enable,
  output logic [AW-1:0]         rf_wr_addr,
  output logic [AW-1:0]         rf_rd_addr,
  output logic [DW-1:0]         rf_wr_data,
  input  logic [DW-1:0]         rf_rd_data
);

  arb_state_e            state;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         owner;
  logic [LOCK_CNT_W-1:0] lock_cnt;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic [NUM_REQ-1:0] grant_oh;
  logic [IW-1:0]      g;
  logic               gnt;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;
  logic               g_write;
  logic               g_lock;
  logic               zero_hit;
  logic [IW-1:0]      g_next;
  logic [IW-1:0]      owner_next;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    grant_oh = '0;
    g        = '0;
    gnt      = 1'b0;
    if (state == LOCKED) begin
      if (req_valid[owner]) begin
        gnt             = 1'b1;
        g               = owner;
        grant_oh[owner] = 1'b1;
      end
    end else begin
      gnt      = pick_any;
      g        = pick_idx;
      grant_oh = pick_oh;
    end
  end

  // With no grant g is 0, so the port shows requester 0's fields.
  assign sel_addr  = req_addr[int'(g)*AW +: AW];
  assign sel_wdata = req_wdata[int'(g)*DW +: DW];
  assign g_write   = req_write[g];
  assign g_lock    = req_lock[g];

`ifdef REGFILE_ARB_ZERO_PROTECT_EN
  assign zero_hit = (sel_addr == '0);
`else
  assign zero_hit = 1'b0;
`endif

  assign g_next     = (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  assign owner_next = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  assign req_ready    = rst ? '0 : grant_oh;
  assign rf_wr_enable = !rst && gnt && g_write && !zero_hit;
  assign rf_wr_addr   = sel_addr;
  assign rf_rd_addr   = sel_addr;
  assign rf_wr_data   = sel_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      lock_cnt  <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= (gnt && !g_write) ? grant_oh : '0;
      if (gnt && !g_write) rsp_data <= zero_hit ? '0 : rf_rd_data;
      case (state)
        ARB: begin
          if (gnt) begin
            if (g_lock) begin
              owner    <= g;
              lock_cnt <= LOCK_CNT_W'(1);
              state    <= LOCKED;
            end else begin
              rr_ptr <= g_next;
            end
          end
        end
        LOCKED: begin
          if (req_valid[owner] && req_lock[owner] &&
              lock_cnt < LOCK_CNT_W'(MAX_LOCK)) begin
            lock_cnt <= lock_cnt + 1'b1;
          end else begin
            state    <= ARB;
            rr_ptr   <= owner_next;
            lock_cnt <= '0;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a simple register-file harness.
module tb_regfile_port_arbiter;

  localparam int NR = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_write;
  logic [NR-1:0]    req_lock;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_data;
  logic             rf_wr_enable;
  logic [AW-1:0]    rf_wr_addr;
  logic [AW-1:0]    rf_rd_addr;
  logic [DW-1:0]    rf_wr_data;
  logic [DW-1:0]    rf_rd_data;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [32];

  regfile_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_lock     (req_lock),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rf_wr_enable (rf_wr_enable),
    .rf_wr_addr   (rf_wr_addr),
    .rf_rd_addr   (rf_rd_addr),
    .rf_wr_data   (rf_wr_data),
    .rf_rd_data   (rf_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file stand-in; address 0 starts nonzero so zero-protect reads are meaningful.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= (i == 0) ? 32'hA5A5A5A5 : 32'h0;
    end else if (rf_wr_enable) begin
      mem[rf_wr_addr] <= rf_wr_data;
    end
  end
  assign rf_rd_data = mem[rf_rd_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_write[i]          = w;
    req_lock[i]           = l;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    logic [63:0] exp_zero_wen;
    logic [63:0] exp_zero_rd;
    logic [1:0]  exp_g;
    rst       = 1'b1;
    req_valid = 2'b11;
    req_write = 2'b11;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset: requests present but nothing may be granted
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_wen", 64'(rf_wr_enable), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rsp_data", 64'(rsp_data), 64'h0);

    @(negedge clk);
    req_valid = '0; req_write = '0;
    rst = 1'b0;
    #1;
    check("idle_ready", 64'(req_ready), 64'h0);
    check("idle_wen", 64'(rf_wr_enable), 64'h0);
    @(posedge clk); #1;
    check("idle_rsp_valid", 64'(rsp_valid), 64'h0);
    check("idle_rsp_data", 64'(rsp_data), 64'h0);

    // Write then read back addr 5
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF);
    #1;
    check("wr_ready", 64'(req_ready), 64'h1);
    check("wr_wen", 64'(rf_wr_enable), 64'h1);
    check("wr_addr", 64'(rf_wr_addr), 64'h5);
    check("wr_data", 64'(rf_wr_data), 64'hDEADBEEF);
    @(posedge clk); #1;
    check("wr_no_rsp", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 1'b0, 5'd5, 32'h0);
    #1;
    check("rd_ready", 64'(req_ready), 64'h1);
    check("rd_wen", 64'(rf_wr_enable), 64'h0);
    check("rd_addr", 64'(rf_rd_addr), 64'h5);
    @(posedge clk); #1;
    check("rd_rsp_valid", 64'(rsp_valid), 64'h1);
    check("rd_rsp_data", 64'(rsp_data), 64'hDEADBEEF);

    // Preload reg3 via req0 (ptr->1) and reg7 via req1 (ptr->0)
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 1'b0, 5'd3, 32'h33333333);
    #1;
    check("pre3_ready", 64'(req_ready), 64'h1);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h77777777);
    #1;
    check("pre7_ready", 64'(req_ready), 64'h2);
    check("pre7_data", 64'(rf_wr_data), 64'h77777777);

    // Round robin: both reading continuously, grants alternate 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        set_req(0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h0);
      end
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      check("rr_ready", 64'(req_ready), 64'(exp_g));
      @(posedge clk); #1;
      check("rr_rsp_valid", 64'(rsp_valid), 64'(exp_g));
      check("rr_rsp_data", 64'(rsp_data), (k % 2 == 0) ? 64'h33333333 : 64'h77777777);
    end

    // Single req0 grant moves ptr to 1 so req1 wins the next arbitration
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h0);
    #1;
    check("ptr_ready", 64'(req_ready), 64'h1);

    // Lock bound: req1 gets MAX_LOCK+1 = 5 grants, req0 on the 6th
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) set_req(1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0);
      exp_g = (k < 5) ? 2'b10 : 2'b01;
      #1;
      check("lock_ready", 64'(req_ready), 64'(exp_g));
      @(posedge clk); #1;
      check("lock_rsp_valid", 64'(rsp_valid), 64'(exp_g));
      check("lock_rsp_data", 64'(rsp_data), (k < 5) ? 64'h77777777 : 64'h33333333);
    end

    // Lock drop: req1 locks, then idles one cycle -> no grant, then req0
    @(negedge clk);
    #1;
    check("drop_lock_ready", 64'(req_ready), 64'h2);
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h0);
    #1;
    check("drop_idle_ready", 64'(req_ready), 64'h0);
    check("drop_idle_wen", 64'(rf_wr_enable), 64'h0);
    @(posedge clk); #1;
    check("drop_idle_rsp", 64'(rsp_valid), 64'h0);
    @(negedge clk);
    #1;
    check("drop_next_ready", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    check("drop_next_rsp", 64'(rsp_valid), 64'h1);

    // Address 0 write and read
`ifdef REGFILE_ARB_ZERO_PROTECT_EN
    exp_zero_wen = 64'h0;
    exp_zero_rd  = 64'h0;
`else
    exp_zero_wen = 64'h1;
    exp_zero_rd  = 64'h1234;
`endif
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h1234);
    #1;
    check("z_wr_ready", 64'(req_ready), 64'h1);
    check("z_wr_wen", 64'(rf_wr_enable), exp_zero_wen);
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    #1;
    check("z_rd_ready", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    check("z_rd_rsp_valid", 64'(rsp_valid), 64'h1);
    check("z_rd_rsp_data", 64'(rsp_data), exp_zero_rd);

    // Reset mid-operation while req1 holds the lock with a response pending
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0);
    #1;
    check("mid_lock_ready", 64'(req_ready), 64'h2);
    @(posedge clk); #1;
    check("mid_pend_rsp", 64'(rsp_valid), 64'h2);
    rst = 1'b1;
    #1;
    check("mid_rst_rsp", 64'(rsp_valid), 64'h0);
    check("mid_rst_data", 64'(rsp_data), 64'h0);
    check("mid_rst_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h0);
    #1;
    check("post_rst_ready", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    check("post_rst_rsp", 64'(rsp_valid), 64'h1);

    @(negedge clk);
    req_valid = '0;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
Shares the register file's single read port and single write port between NUM_REQ requesters, for example core datapath, debug unit and init/DMA engine.
- Arbitration is round-robin, with a valid/ready handshake per requester.
- An optional bounded lock lets one requester hold the port for atomic read-modify-write sequences.
- Sits between the requesters and register_file; drives its wr_enable, rd_addr, wr_addr and wr_data, and consumes rd_data.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- NUM_OF_SETS, 32: register count; address width is AW = $clog2(NUM_OF_SETS).
- DATA_BUS_WIDTH, 32: data width DW.
- MAX_LOCK, 4: maximum consecutive locked grants to one requester (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- req_valid  in  NUM_REQ  per-requester access request
- req_write  in  NUM_REQ  1=write, 0=read
- req_lock  in  NUM_REQ  request to retain grant on following cycles
- req_addr  in  NUM_REQ*AW  packed addresses; requester i at [i*AW +: AW]
- req_wdata  in  NUM_REQ*DW  packed write data
- req_ready  out  NUM_REQ  one-hot grant; access accepted this cycle
- rsp_valid  out  NUM_REQ  one-hot read response valid
- rsp_data  out  DW  read data for the requester flagged in rsp_valid
- rf_wr_enable  out  1  to register file
- rf_wr_addr  out  AW  to register file
- rf_rd_addr  out  AW  to register file
- rf_wr_data  out  DW  to register file
- rf_rd_data  in  DW  async read data from register file

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=ARB, rr_ptr=0, owner=0, lock_cnt=0, rsp_valid=0, rsp_data=0. While rst is high, req_ready=0 and rf_wr_enable=0.
- Grant is combinational and at most one per cycle. Selected index g is the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. req_ready[g]=1 in the same cycle.
- Write grant:
  - rf_wr_enable=1, rf_wr_addr=addr[g], rf_wr_data=wdata[g].
  - Data lands at the next clk edge.
- Read grant:
  - rf_rd_addr=addr[g].
  - rf_rd_data is registered into rsp_data at the edge. rsp_valid[g]=1 for exactly one cycle after the grant.
  - Read latency is 1 cycle.
- No grant: rf_wr_enable=0; rf_rd_addr, rf_wr_addr and rf_wr_data hold the requester-0 values (don't-care); rsp_valid=0 next cycle.
- Read-after-write to the same address on consecutive grants returns the new data. No forwarding is needed because the write completes before the read cycle.
- State ARB:
  - On a grant with req_lock[g]=0: rr_ptr <= (g+1) mod NUM_REQ.
  - On a grant with req_lock[g]=1: owner <= g, lock_cnt <= 1, go to LOCKED; rr_ptr is unchanged.
- State LOCKED:
  - Only owner may be granted; req_ready of all others stays 0.
  - If req_valid[owner] && req_lock[owner] && lock_cnt < MAX_LOCK: grant, lock_cnt++.
  - If req_valid[owner] && (!req_lock[owner] || lock_cnt==MAX_LOCK): grant this final access, go to ARB, rr_ptr <= owner+1.
  - If !req_valid[owner]: no grant, go to ARB, rr_ptr <= owner+1. The lock is dropped on the first idle cycle.
- MAX_LOCK bounds the owner to at most MAX_LOCK+1 consecutive grants, so other requesters cannot starve.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Requesters hold valid, addr and data stable until ready; the arbiter does not check this.
- Reset asserted mid-operation: all state clears immediately. The lock is released and no pending rsp_valid is emitted after reset.

Optional Feature:
- Macro: REGFILE_ARB_ZERO_PROTECT_EN.
- Defined:
  - Writes to address 0 are accepted (req_ready=1) but rf_wr_enable stays 0.
  - Reads of address 0 return rsp_data=0, independent of rf_rd_data.
- Undefined: address 0 is treated like any other register.

Decomposition:
- Package regfile_arb_pkg holds:
  - arb_state_e enum {ARB, LOCKED}.
  - Function clog2-safe width helper.
  - Localparam LOCK_CNT_W=4.
- One natural sub-module: rr_pick. It is combinational, takes valid vector and pointer, and returns one-hot grant plus index. Instantiated once.

Test Plan:
- Reset then idle: after rst pulse, all req_valid=0 -> req_ready=0, rf_wr_enable=0, rsp_valid=0, rsp_data=0.
- Write then read: req0 writes addr 5 data 0xDEADBEEF; next cycle req0 reads addr 5 -> rsp_valid=2'b01 one cycle later with rsp_data=0xDEADBEEF.
- Round-robin fairness: req0 and req1 both continuously valid reading addr 3 and 7 -> grants alternate 0,1,0,1; rsp_data alternates reg3/reg7 contents.
- Lock bound: MAX_LOCK=4, req1 holds lock and valid, req0 valid -> req1 gets 5 consecutive grants, then req0 granted on the 6th cycle.
- Lock drop: req1 locks, then deasserts valid for one cycle -> no grant that cycle, state returns to ARB, req0 granted next.
- Zero protect (macro defined): write addr 0 data 0x1234, then read addr 0 -> req_ready=1, rf_wr_enable=0, rsp_data=0. Without the macro the same read returns 0x1234.
